// File: rtl/btn_counter_ctrl.sv
// -----------------------------------------------------------------------------
// btn_counter_ctrl
//   Source of the 8-bit value shown on the 3-digit multiplexed display.
//   Synchronises and debounces the start/stop and clear pushbuttons, and runs
//   an up/down counter that steps once every TICK_DIV clocks while running.
//   The count wraps between 0 and MAX_COUNT in both directions.
//
// Parameters
//   DEBOUNCE_CYCLES  stable synchronised samples needed to accept a level change (>=1)
//   TICK_DIV         clk cycles per count step while running (>=2)
//   MAX_COUNT        highest count value and wrap point (1..255)
//
// Ports
//   clk             in   system clock, rising edge
//   rst             in   asynchronous active-low reset
//   btn_start_stop  in   raw pushbutton, press toggles run/stop
//   btn_clear       in   raw pushbutton, press zeroes count and stops
//   dir_up          in   raw level switch, 1 = up, 0 = down (synchronised only)
//   count           out  current count (registered)
//   running         out  1 while in RUNNING state
//   count_upd       out  one-cycle pulse when count shows a newly written value
// -----------------------------------------------------------------------------
module btn_counter_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TICK_DIV        = 10,
   parameter int unsigned MAX_COUNT       = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       dir_up,
   output logic [7:0] count,
   output logic       running,
   output logic       count_upd
);

   localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam int unsigned PSW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PSW-1:0] PS_LAST = PSW'(TICK_DIV - 1);
   localparam logic [7:0]     CNT_MAX = 8'(MAX_COUNT);

   // Bit 0 = start/stop, bit 1 = clear, bit 2 = direction.
   localparam int unsigned B_SS  = 0;
   localparam int unsigned B_CL  = 1;
   localparam int unsigned B_DIR = 2;

   typedef enum logic {
      S_STOPPED,
      S_RUNNING
   } state_t;

   logic [2:0]            sync1_q;
   logic [2:0]            sync2_q;
   logic [1:0]            deb_q;
   logic [1:0]            debp_q;
   logic [1:0]            press_q;
   logic [1:0][DBW-1:0]   dbc_q;

   state_t                state_q, state_d;
   logic [PSW-1:0]        pre_q, pre_d;
   logic [7:0]            count_q, count_d;
   logic                  upd_q, upd_d;
   logic                  tick;

   // ---------------------------------------------------------------------------
   // Input synchronisers, debounce and press detection
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         debp_q  <= '0;
         press_q <= '0;
         dbc_q   <= '0;
      end else begin
         sync1_q <= {dir_up, btn_clear, btn_start_stop};
         sync2_q <= sync1_q;
         debp_q  <= deb_q;
         // Registered rising-edge compare of the debounced level: one pulse per press.
         press_q <= deb_q & ~debp_q;
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               dbc_q[i] <= '0;
            end else if (dbc_q[i] == DB_LAST) begin
               // This sample makes DEBOUNCE_CYCLES consecutive differing samples.
               deb_q[i] <= ~deb_q[i];
               dbc_q[i] <= '0;
            end else begin
               dbc_q[i] <= dbc_q[i] + 1'b1;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Run/stop FSM, prescaler and counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_STOPPED;
         pre_q   <= '0;
         count_q <= '0;
         upd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         count_q <= count_d;
         upd_q   <= upd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      count_d = count_q;
      upd_d   = 1'b0;
      tick    = (state_q == S_RUNNING) && (pre_q == PS_LAST);

      if (state_q == S_RUNNING) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end

      if (tick) begin
         upd_d = 1'b1;
         if (sync2_q[B_DIR]) begin
            count_d = (count_q == CNT_MAX) ? '0 : count_q + 8'd1;
         end else begin
            count_d = (count_q == '0) ? CNT_MAX : count_q - 8'd1;
         end
      end

      // A start/stop press coincident with a tick keeps the step, then stops.
      if (press_q[B_SS]) begin
         if (state_q == S_RUNNING) begin
            state_d = S_STOPPED;
         end else begin
            state_d = S_RUNNING;
            pre_d   = '0;
         end
      end

      // Clear overrides any step or start/stop press in the same cycle.
      if (press_q[B_CL]) begin
         count_d = '0;
         pre_d   = '0;
         upd_d   = 1'b1;
         state_d = S_STOPPED;
      end
   end

   assign count     = count_q;
   assign running   = (state_q == S_RUNNING);
   assign count_upd = upd_q;

endmodule

// File: tb/tb_btn_counter_ctrl.sv
module tb_btn_counter_ctrl;

   localparam int D = 4;
   localparam int T = 3;
   localparam int M = 9;
   localparam int HMAX = 8192;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ss  = 1'b0;
   logic       cl  = 1'b0;
   logic       dir = 1'b0;
   logic [7:0] count;
   logic       running;
   logic       count_upd;

   always #5 clk = ~clk;

   btn_counter_ctrl #(
      .DEBOUNCE_CYCLES(D),
      .TICK_DIV(T),
      .MAX_COUNT(M)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_start_stop(ss),
      .btn_clear(cl),
      .dir_up(dir),
      .count(count),
      .running(running),
      .count_upd(count_upd)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: raw input history per edge since reset release, debounced
   // level history, and the run/count behaviour in plain modular arithmetic.
   int  e;
   bit  r_b  [2][HMAX];
   bit  d_b  [2][HMAX];
   bit  r_dir[HMAX];
   bit  lev  [2];
   int  run  [2];
   int  m_count;
   bit  m_run;
   bit  m_upd;
   int  m_start;

   task automatic model_reset();
      e = 0;
      for (int b = 0; b < 2; b++) begin
         lev[b] = 0; run[b] = 0; r_b[b][0] = 0; d_b[b][0] = 0;
      end
      r_dir[0] = 0;
      m_count = 0; m_run = 0; m_upd = 0; m_start = 0;
   endtask

   // Drive one set of inputs for one clock edge, advance the model, compare.
   task automatic step(input bit a_ss, input bit a_cl, input bit a_dir);
      bit pr [2];
      bit syn;
      bit tick;
      bit dsync;
      ss = a_ss; cl = a_cl; dir = a_dir;
      e++;
      if (e >= HMAX) begin
         $display("FAIL model_history: got %0d expected below %0d", e, HMAX);
         $fatal(1);
      end
      r_b[0][e] = a_ss; r_b[1][e] = a_cl; r_dir[e] = a_dir;
      for (int b = 0; b < 2; b++) begin
         syn = (e >= 2) ? r_b[b][e-2] : 1'b0;
         if (syn == lev[b]) run[b] = 0;
         else begin
            run[b]++;
            if (run[b] == D) begin lev[b] = !lev[b]; run[b] = 0; end
         end
         d_b[b][e] = lev[b];
         pr[b] = (e >= 3) && d_b[b][e-2] && !d_b[b][e-3];
      end
      dsync = (e >= 2) ? r_dir[e-2] : 1'b0;
      tick  = m_run && (((e - m_start) % T) == 0);
      m_upd = 0;
      if (pr[1]) begin
         m_count = 0; m_upd = 1; m_run = 0;
      end else begin
         if (tick) begin
            m_upd = 1;
            m_count = dsync ? (m_count + 1) % (M + 1) : (m_count + M) % (M + 1);
         end
         if (pr[0]) begin
            if (m_run) m_run = 0;
            else begin m_run = 1; m_start = e; end
         end
      end
      @(posedge clk); #1;
      chk("count", count, m_count);
      chk("running", running, m_run);
      chk("count_upd", count_upd, m_upd);
   endtask

   typedef struct {
      bit ss;
      bit cl;
      bit dir;
      int n;
      int exp_count;
      bit exp_run;
   } vec_t;

   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      tbl.push_back('{0, 0, 0, 50, 0, 0});   // idle after reset
      tbl.push_back('{1, 0, 0,  2, 0, 0});   // bounce
      tbl.push_back('{0, 0, 0,  2, 0, 0});
      tbl.push_back('{1, 0, 0,  2, 0, 0});
      tbl.push_back('{0, 0, 0, 10, 0, 0});
      tbl.push_back('{1, 0, 1, 20, 4, 1});   // hold start: run up
      tbl.push_back('{0, 0, 1, 18, 0, 1});   // release, wrap 9->0
      tbl.push_back('{0, 0, 0,  6, 8, 1});   // down: 9, 8
      tbl.push_back('{0, 0, 0,  3, 7, 1});
      tbl.push_back('{0, 1, 0, 12, 0, 0});   // clear lands at count 5
      tbl.push_back('{0, 0, 0, 12, 0, 0});   // no further steps
      tbl.push_back('{1, 1, 1, 12, 0, 0});   // both together: clear wins
      tbl.push_back('{0, 0, 1, 12, 0, 0});

      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_count", count, 0);
      chk("reset_running", running, 0);
      chk("reset_upd", count_upd, 0);
      rst = 1'b1;
      model_reset();

      foreach (tbl[k]) begin
         for (int c = 0; c < tbl[k].n; c++) step(tbl[k].ss, tbl[k].cl, tbl[k].dir);
         chk($sformatf("tbl%0d_count", k), count, tbl[k].exp_count);
         chk($sformatf("tbl%0d_running", k), running, tbl[k].exp_run);
      end

      // Press latency: running rises on the 8th edge of a held press (D+3 edges
      // to the press pulse, one more to the state change).
      for (int c = 0; c < 7; c++) step(1, 0, 1);
      chk("latency_before", running, 0);
      step(1, 0, 1);
      chk("latency_after", running, 1);
      for (int c = 0; c < 10; c++) step(0, 0, 1);
      chk("run_steps", count, 3);

      // Asynchronous reset mid-count.
      rst = 1'b0;
      #1;
      chk("async_rst_count", count, 0);
      chk("async_rst_running", running, 0);
      chk("async_rst_upd", count_upd, 0);
      ss = 0; cl = 0; dir = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      for (int c = 0; c < 20; c++) step(0, 0, 1);
      chk("post_rst_idle_count", count, 0);
      chk("post_rst_idle_running", running, 0);
      for (int c = 0; c < 12; c++) step(1, 0, 1);
      chk("post_rst_restart", running, 1);
      for (int c = 0; c < 6; c++) step(0, 0, 1);

      // Randomised segments against the reference model.
      for (int s = 0; s < 150; s++) begin
         int  len;
         bit  rs, rc, rd;
         len = $urandom_range(1, 12);
         rs  = ($urandom_range(0, 2) == 0);
         rc  = ($urandom_range(0, 7) == 0);
         rd  = $urandom_range(0, 1) != 0;
         for (int c = 0; c < len; c++) step(rs, rc, rd);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
